seg7_scroll_ctrl: RTL and testbench
===================================

SEG7_SCROLL_CTRL -- requirements
Module: seg7_scroll_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 50000000, giving scroll tick period in Clock cycles; legal range DIV >= 8.
REQ-002 SHALL have parameter MSG_DEPTH, default 16, giving message buffer depth in characters.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL have port Clock  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port Reset  input  1  synchronous active-high reset.
REQ-006 SHALL have port Enable  input  1  1 = scroll ticks advance, 0 = tick counter holds.
REQ-007 SHALL have port LoadWr  input  1  message buffer write strobe.
REQ-008 SHALL have port LoadAddr  input  4  buffer write index.
REQ-009 SHALL have port LoadData  input  7  segment pattern to store.
REQ-010 SHALL have port MsgLen  input  5  active message length in characters.
REQ-011 SHALL have port Data  output  7  pattern to the display register bank.
REQ-012 SHALL have port Addr  output  3  digit select to the display bank, 5 = H5 (leftmost) ... 0 = H0.
REQ-013 SHALL have port Sel  output  1  display bank write enable, one cycle per digit write.
REQ-014 SHALL have port Busy  output  1  high while a frame update is in progress.
REQ-015 SHALL have port Wrap  output  1  one-cycle pulse when the scroll offset returns to 0.

Function
REQ-016 SHALL count Clock cycles 0..DIV-1 while Enable=1, asserting an internal tick for one cycle at count DIV-1 and then restarting at 0.
REQ-017 SHALL use FSM states IDLE, WRITE, ADVANCE: IDLE->WRITE on tick; WRITE->ADVANCE after the sixth digit write; ADVANCE->IDLE after one cycle.
REQ-018 SHALL, on entry to WRITE, latch the effective length L = MsgLen clamped to 1..MSG_DEPTH (0 -> 1, >16 -> 16), and force offset to 0 if offset >= L.
REQ-019 SHALL, in WRITE, issue six registered writes on consecutive cycles with Sel=1, Addr = 5,4,3,2,1,0 in order.
REQ-020 SHALL, for write k (k = 0..5), drive Data = buffer[(offset + k) mod L] using a wrapping index counter (increment, reset to 0 at L), never a divider.
REQ-021 SHALL drive Sel=0 in IDLE and ADVANCE; Data and Addr hold their last values when Sel=0.
REQ-022 SHALL, in ADVANCE, set offset = offset+1, or 0 with Wrap=1 for that cycle if offset+1 >= L.
REQ-023 SHALL hold Busy=1 in WRITE and ADVANCE (7 cycles per frame) and 0 in IDLE.
REQ-024 SHALL write LoadData to buffer[LoadAddr] on LoadWr=1 only while Busy=0; LoadWr while Busy=1 SHALL be ignored; LoadAddr >= MSG_DEPTH SHALL be ignored.
REQ-025 SHALL complete an in-progress frame when Enable drops mid-frame; only the tick counter stalls.
REQ-026 SHALL treat MsgLen changes mid-frame as taking effect at the next frame's latch (REQ-018).

Reset
REQ-027 SHALL, when Reset=1 at a Clock edge, set state IDLE, tick count 0, offset 0, index 0, Data=0, Addr=0, Sel=0, Busy=0, Wrap=0, and all buffer entries to 7'h7F (all segments off, active-low).
REQ-028 SHALL give Reset priority over LoadWr, tick and any FSM transition, including abort mid-WRITE with Sel=0 the next cycle.

Structure
REQ-029 SHALL place FSM state encoding, DIGITS=6 and default MSG_DEPTH in shared package seg7_scroll_pkg.
REQ-030 SHALL implement the tick divider as sub-module scroll_tick (inputs Clock, Reset, Enable; output tick; parameter DIV).
REQ-031 SHALL connect Data/Addr/Sel directly to the display register bank's Data/Addr/Sel, with bank Resetn = ~Reset.

Verification (DIV=10)
REQ-032 SHALL check reset: after Reset, Sel=0, Busy=0, Data=0, Addr=0; first frame with no loads writes 7'h7F to all six digits.
REQ-033 SHALL check basic frame: load buffer[i]=i+1 (i=0..7), MsgLen=8; first tick -> writes (Addr,Data) = (5,1),(4,2),(3,3),(2,4),(1,5),(0,6); next frame starts with 2.
REQ-034 SHALL check wrap: MsgLen=8, offset 6 frame -> Data 7,8,1,2,3,4; offset 7 ADVANCE -> Wrap pulse, offset 0.
REQ-035 SHALL check short message: MsgLen=2, buffer 7'h11,7'h22 -> Data alternates 11,22,11,22,11,22; MsgLen=0 -> all six digits = buffer[0].
REQ-036 SHALL check busy lockout: LoadWr to buffer[0] during WRITE -> buffer unchanged; same write in IDLE -> applied.
REQ-037 SHALL check Reset asserted on third WRITE cycle -> Sel=0 next cycle, offset 0, buffer 7'h7F; Enable=0 -> no Sel pulses for 50 cycles.

Source files
------------

// File: rtl/seg7_scroll_pkg.sv
// rtl/seg7_scroll_pkg.sv - shared constants and helpers for the scrolling seven-segment controller
package seg7_scroll_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WRITE   = 2'd1;
  localparam logic [1:0] ST_ADVANCE = 2'd2;

  localparam int         DIGITS        = 6;
  localparam int         MSG_DEPTH_DEF = 16;
  localparam logic [6:0] BLANK         = 7'h7F;

  // Message length actually used for a frame: never 0, never beyond the buffer
  function automatic logic [4:0] clamp_len(input logic [4:0] msg_len, input int depth);
    if (msg_len == 5'd0) return 5'd1;
    if (int'(msg_len) > depth) return 5'(depth);
    return msg_len;
  endfunction

endpackage

// File: rtl/seg7_scroll_ctrl_if.sv
// rtl/seg7_scroll_ctrl_if.sv - message load bus and display bank write bus
interface seg7_scroll_ctrl_if;

  logic       LoadWr;
  logic [3:0] LoadAddr;
  logic [6:0] LoadData;
  logic [4:0] MsgLen;
  logic [6:0] Data;
  logic [2:0] Addr;
  logic       Sel;

  modport master (
    output LoadWr, LoadAddr, LoadData, MsgLen,
    input  Data, Addr, Sel
  );

  modport slave (
    input  LoadWr, LoadAddr, LoadData, MsgLen,
    output Data, Addr, Sel
  );

endinterface

// File: rtl/seg7_scroll_ctrl_tick.sv
// rtl/seg7_scroll_ctrl_tick.sv - scroll tick divider, one-cycle tick every DIV enabled cycles
module scroll_tick #(
  parameter int DIV = 50000000
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Enable,
  output logic tick
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] count;

  assign tick = Enable && (count == CW'(DIV - 1));

  always_ff @(posedge Clock) begin
    if (Reset) begin
      count <= '0;
    end else if (Enable) begin
      count <= tick ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/seg7_scroll_ctrl.sv
// rtl/seg7_scroll_ctrl.sv - scrolls a message buffer across six display digits, one frame per tick
module seg7_scroll_ctrl
  import seg7_scroll_pkg::*;
#(
  parameter int DIV       = 50000000,
  parameter int MSG_DEPTH = MSG_DEPTH_DEF
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Enable,
  seg7_scroll_ctrl_if.slave   bus,
  output logic                Busy,
  output logic                Wrap
);

  logic       tick;
  logic [1:0] state;
  logic [6:0] msg_buf [MSG_DEPTH];
  logic [4:0] len;
  logic [3:0] offset;
  logic [3:0] idx;
  logic [6:0] data_q;
  logic [2:0] addr_q;
  logic       sel_q;

  logic [4:0] len_new;
  logic [3:0] start;
  logic [3:0] start_next;
  logic [3:0] idx_next;
  logic       load_ok;

  scroll_tick #(.DIV(DIV)) u_tick (
    .Clock  (Clock),
    .Reset  (Reset),
    .Enable (Enable),
    .tick   (tick)
  );

  // Frame start values are derived from the length latched at this same edge
  assign len_new    = clamp_len(bus.MsgLen, MSG_DEPTH);
  assign start      = ({1'b0, offset} >= len_new) ? 4'd0 : offset;
  assign start_next = ({1'b0, start} + 5'd1 >= len_new) ? 4'd0 : start + 4'd1;
  assign idx_next   = ({1'b0, idx} + 5'd1 >= len) ? 4'd0 : idx + 4'd1;
  assign load_ok    = bus.LoadWr && (state == ST_IDLE) && (int'(bus.LoadAddr) < MSG_DEPTH);

  assign Busy     = (state != ST_IDLE);
  assign Wrap     = (state == ST_ADVANCE) && ({1'b0, offset} + 5'd1 >= len);
  assign bus.Data = data_q;
  assign bus.Addr = addr_q;
  assign bus.Sel  = sel_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < MSG_DEPTH; i++) msg_buf[i] <= BLANK;
    end else if (load_ok) begin
      msg_buf[bus.LoadAddr] <= bus.LoadData;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state  <= ST_IDLE;
      len    <= 5'd1;
      offset <= 4'd0;
      idx    <= 4'd0;
      data_q <= 7'd0;
      addr_q <= 3'd0;
      sel_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (tick) begin
            state  <= ST_WRITE;
            len    <= len_new;
            offset <= start;
            data_q <= msg_buf[start];
            addr_q <= 3'(DIGITS - 1);
            sel_q  <= 1'b1;
            idx    <= start_next;
          end
        end
        ST_WRITE: begin
          // Addr doubles as the write counter; the H0 write ends the frame
          if (addr_q == 3'd0) begin
            state <= ST_ADVANCE;
            sel_q <= 1'b0;
          end else begin
            addr_q <= addr_q - 3'd1;
            data_q <= msg_buf[idx];
            idx    <= idx_next;
          end
        end
        ST_ADVANCE: begin
          offset <= Wrap ? 4'd0 : offset + 4'd1;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_scroll_ctrl.sv
// tb/tb_seg7_scroll_ctrl.sv - self-checking bench for seg7_scroll_ctrl
module tb_seg7_scroll_ctrl;
  import seg7_scroll_pkg::*;

  localparam int DIV = 10;

  typedef struct {
    logic [4:0]      ml;
    logic [5:0][6:0] d;
    bit              w;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic Busy;
  logic Wrap;

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] mbuf [16];
  int         moff;
  vec_t       tbl [14];

  always #5 clk = ~clk;

  seg7_scroll_ctrl_if bus ();

  seg7_scroll_ctrl #(.DIV(DIV), .MSG_DEPTH(16)) dut (
    .Clock  (clk),
    .Reset  (rst),
    .Enable (en),
    .bus    (bus),
    .Busy   (Busy),
    .Wrap   (Wrap)
  );

  function automatic vec_t mk(input logic [4:0] ml, input logic [6:0] d0, input logic [6:0] d1,
                              input logic [6:0] d2, input logic [6:0] d3, input logic [6:0] d4,
                              input logic [6:0] d5, input bit w);
    vec_t v;
    v.ml = ml;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3; v.d[4] = d4; v.d[5] = d5;
    v.w = w;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.LoadWr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) mbuf[i] = 7'h7F;
    moff = 0;
  endtask

  task automatic load(input logic [3:0] a, input logic [6:0] d);
    bus.LoadWr = 1'b1;
    bus.LoadAddr = a;
    bus.LoadData = d;
    @(negedge clk);
    bus.LoadWr = 1'b0;
    mbuf[a] = d;
  endtask

  // Reference frame: six characters starting at the scroll offset, modulo the clamped length
  task automatic model_frame(input logic [4:0] ml, output logic [5:0][6:0] d, output bit w);
    int L;
    L = (ml == 5'd0) ? 1 : ((int'(ml) > 16) ? 16 : int'(ml));
    if (moff >= L) moff = 0;
    for (int k = 0; k < 6; k++) d[k] = mbuf[(moff + k) % L];
    w = (moff + 1 >= L);
    moff = w ? 0 : moff + 1;
  endtask

  task automatic capture(input bit poke_load, input bit poke_len, output logic [5:0][6:0] d,
                         output logic [5:0][2:0] a, output bit w, output bit ok);
    int t;
    t = 0; ok = 1'b0; w = 1'b0; d = '0; a = '0;
    while (bus.Sel !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (bus.Sel !== 1'b1) return;
    ok = 1'b1;
    for (int k = 0; k < 6; k++) begin
      d[k] = bus.Data;
      a[k] = bus.Addr;
      if (bus.Sel !== 1'b1 || Busy !== 1'b1) ok = 1'b0;
      if (poke_load && k == 2) begin
        bus.LoadWr = 1'b1;
        bus.LoadAddr = 4'd0;
        bus.LoadData = ~mbuf[0];
      end
      if (k == 3) begin
        bus.LoadWr = 1'b0;
        if (poke_len) bus.MsgLen = 5'($urandom_range(0, 31));
      end
      @(negedge clk);
    end
    if (bus.Sel !== 1'b0 || Busy !== 1'b1) ok = 1'b0;
    w = Wrap;
    @(negedge clk);
    if (Busy !== 1'b0 || Wrap !== 1'b0) ok = 1'b0;
  endtask

  task automatic run_check(input string name, input logic [4:0] ml, input bit pl, input bit pln,
                           input logic [5:0][6:0] exp_d, input bit exp_w);
    logic [5:0][6:0] d;
    logic [5:0][2:0] a;
    bit w, ok;
    bus.MsgLen = ml;
    capture(pl, pln, d, a, w, ok);
    chk($sformatf("%s shape", name), 32'(ok), 32'd1);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("%s data%0d", name, k), 32'(d[k]), 32'(exp_d[k]));
      chk($sformatf("%s addr%0d", name, k), 32'(a[k]), 32'(5 - k));
    end
    chk($sformatf("%s wrap", name), 32'(w), 32'(exp_w));
  endtask

  task automatic run_model(input string name, input logic [4:0] ml, input bit pl, input bit pln);
    logic [5:0][6:0] ed;
    bit ew;
    model_frame(ml, ed, ew);
    run_check(name, ml, pl, pln, ed, ew);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0][6:0] dd;
    bit ww;
    int t, cnt;

    tbl[0]  = mk(5'd8,  7'd1,  7'd2,  7'd3,  7'd4,  7'd5,  7'd6,  1'b0);
    tbl[1]  = mk(5'd8,  7'd2,  7'd3,  7'd4,  7'd5,  7'd6,  7'd7,  1'b0);
    tbl[2]  = mk(5'd8,  7'd3,  7'd4,  7'd5,  7'd6,  7'd7,  7'd8,  1'b0);
    tbl[3]  = mk(5'd8,  7'd4,  7'd5,  7'd6,  7'd7,  7'd8,  7'd1,  1'b0);
    tbl[4]  = mk(5'd8,  7'd5,  7'd6,  7'd7,  7'd8,  7'd1,  7'd2,  1'b0);
    tbl[5]  = mk(5'd8,  7'd6,  7'd7,  7'd8,  7'd1,  7'd2,  7'd3,  1'b0);
    tbl[6]  = mk(5'd8,  7'd7,  7'd8,  7'd1,  7'd2,  7'd3,  7'd4,  1'b0);
    tbl[7]  = mk(5'd8,  7'd8,  7'd1,  7'd2,  7'd3,  7'd4,  7'd5,  1'b1);
    tbl[8]  = mk(5'd2,  7'h11, 7'h22, 7'h11, 7'h22, 7'h11, 7'h22, 1'b0);
    tbl[9]  = mk(5'd2,  7'h22, 7'h11, 7'h22, 7'h11, 7'h22, 7'h11, 1'b1);
    tbl[10] = mk(5'd0,  7'h11, 7'h11, 7'h11, 7'h11, 7'h11, 7'h11, 1'b1);
    tbl[11] = mk(5'd20, 7'h11, 7'h22, 7'd3,  7'd4,  7'd5,  7'd6,  1'b0);
    tbl[12] = mk(5'd16, 7'h22, 7'd3,  7'd4,  7'd5,  7'd6,  7'd7,  1'b0);
    tbl[13] = mk(5'd2,  7'h11, 7'h22, 7'h11, 7'h22, 7'h11, 7'h22, 1'b0);

    en = 1'b0;
    bus.LoadWr = 1'b0;
    bus.LoadAddr = 4'd0;
    bus.LoadData = 7'd0;
    bus.MsgLen = 5'd8;
    do_reset();
    chk("reset sel",  32'(bus.Sel),  32'd0);
    chk("reset busy", 32'(Busy),     32'd0);
    chk("reset data", 32'(bus.Data), 32'd0);
    chk("reset addr", 32'(bus.Addr), 32'd0);
    chk("reset wrap", 32'(Wrap),     32'd0);
    en = 1'b1;
    run_model("blank_frame", 5'd8, 1'b0, 1'b0);

    do_reset();
    for (int i = 0; i < 8; i++) load(4'(i), 7'(i + 1));
    en = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (i == 8) begin
        en = 1'b0;
        load(4'd0, 7'h11);
        load(4'd1, 7'h22);
        en = 1'b1;
      end
      run_check($sformatf("tbl%0d", i), tbl[i].ml, 1'b0, 1'b0, tbl[i].d, tbl[i].w);
      model_frame(tbl[i].ml, dd, ww);
    end

    run_model("lock_busy", 5'd1, 1'b1, 1'b0);
    run_model("lock_after", 5'd1, 1'b0, 1'b0);
    en = 1'b0;
    load(4'd0, 7'h55);
    en = 1'b1;
    run_model("lock_idle", 5'd1, 1'b0, 1'b0);

    // Reset lands on the third write of a frame
    bus.MsgLen = 5'd8;
    t = 0;
    while (bus.Sel !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("rst_mid wait", 32'(bus.Sel), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    en = 1'b0;
    chk("rst_mid sel",  32'(bus.Sel), 32'd0);
    chk("rst_mid busy", 32'(Busy),    32'd0);
    for (int i = 0; i < 16; i++) mbuf[i] = 7'h7F;
    moff = 0;
    for (int i = 0; i < 3; i++) load(4'(i), 7'(7'h40 + i));
    en = 1'b1;
    run_model("rst_mid frame", 5'd8, 1'b0, 1'b0);

    en = 1'b0;
    cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.Sel === 1'b1) cnt++;
    end
    chk("enable_low no_sel", 32'(cnt), 32'd0);

    for (int it = 0; it < 16; it++) begin
      en = 1'b0;
      repeat ($urandom_range(0, 3)) load(4'($urandom_range(0, 15)), 7'($urandom_range(0, 127)));
      en = 1'b1;
      run_model($sformatf("rand%0d", it), 5'($urandom_range(0, 31)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
